conv_window_gen: RTL
====================

Name: conv_window_gen

Overview:
- Producer side of the KERNEL_W x KERNEL_W convolution window interface.
- Accepts a raster-order pixel stream, one pixel per valid cycle.
- Buffers KERNEL_W-1 previous image lines and emits a full square window with a valid strobe to the convolution stage.
- Produces only fully-populated windows, so the output image is (IMG_W-KERNEL_W+1) x (IMG_H-KERNEL_W+1). No backpressure, matching the conv stage.

Parameters:
- DATA_W, 8, pixel width in bits
- KERNEL_W, 3, window side length; >= 2
- IMG_W, 640, pixels per line; >= KERNEL_W
- IMG_H, 480, lines per frame; >= KERNEL_W

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- pixel_i  in  DATA_W  raster pixel
- pixel_valid_i  in  1  pixel_i accepted this cycle
- sof_i  in  1  start of frame; qualifies the pixel accepted with it
- window_o  out  DATA_W x [KERNEL_W][KERNEL_W]  window; [i][j]: i=row (0 = oldest line), j=col (0 = leftmost)
- window_valid_o  out  1  window_o holds a complete window this cycle

Behaviour:
- Reset (async assert, sync deassert):
  - col/row counters = 0
  - window_o = all zeros
  - window_valid_o = 0
  - line buffer storage is not cleared
- Counters: col in [0, IMG_W-1], row in [0, IMG_H-1]; advance only on accepted pixels (pixel_valid_i=1).
  - col==IMG_W-1: col -> 0, row increments.
  - row==IMG_H-1 with col wrap: row -> 0. Back-to-back frames need no sof_i.
- sof_i with pixel_valid_i: that pixel is position (0,0) regardless of counter state; counters continue from (0,1). sof_i without pixel_valid_i is ignored.
- Line buffers: KERNEL_W-1 chained delays of exactly IMG_W accepted pixels.
  - Buffer k outputs the pixel from k+1 lines above the current pixel.
  - Write and read happen on the same accepted pixel; pointer wraps at IMG_W.
- Window register, on each accepted pixel:
  - all columns shift left by one (column j takes column j+1);
  - column KERNEL_W-1 is loaded with {oldest line buffer output, ..., newest line buffer output, pixel_i}, row 0 = oldest line.
  - Idle cycles hold the window unchanged.
- window_valid_o is registered. It is 1 for exactly one cycle after the edge accepting a pixel at (row, col) with row>=KERNEL_W-1 and col>=KERNEL_W-1; otherwise 0.
- Latency: 1 clock from accepting the last pixel of a window to window_valid_o.
- Windows straddling a line wrap (col<KERNEL_W-1) may hold stale columns but are never flagged valid.
- Reset mid-frame: the next frame starts clean at (0,0). Stale line buffer contents only affect rows < KERNEL_W-1, which are masked.
- Throughput: one window per clock at full input rate.

Optional Feature:
- Macro: CONV_WINDOW_GEN_FRAME_DONE_EN
- Defined: adds output frame_done_o (1 bit, reset 0). It pulses for one cycle together with the window_valid_o for pixel (IMG_H-1, IMG_W-1).
- Also defined: adds output win_cnt_o (32 bit, reset 0). It counts valid windows in the current frame and clears on sof_i or on frame wrap.
- Undefined: neither port exists; no logic is added.

Decomposition:
- Shared package img_proc_pkg:
  - pixel_t (logic [DATA_W-1:0])
  - window_t (pixel_t [KERNEL_W-1:0][KERNEL_W-1:0])
  - default DATA_W / KERNEL_W constants
  - both modules use these so the window type and orientation match the conv stage exactly.
- One sub-module, conv_line_buffer:
  - single IMG_W-deep circular delay line of DATA_W bits, with write-enable and a combinational/registered-aligned read of the oldest entry;
  - instantiated KERNEL_W-1 times in a chain.

Test Plan:
- IMG_W=4, IMG_H=4, KERNEL_W=3, pixels 0..15 continuous, sof_i on pixel 0:
  - exactly 4 valid windows;
  - first window rows {0,1,2},{4,5,6},{8,9,10} one clock after pixel 10;
  - subsequent window_o[0][0] = 1, 4, 5.
- Same frame with random idle gaps on pixel_valid_i: identical 4 windows in order; each valid exactly 1 clock after its completing pixel; no extra pulses.
- Line wrap: no window_valid_o after pixels 12 and 13 (col 0, 1 of row 3); valid after pixels 14 and 15 only.
- Two back-to-back frames without a second sof_i: second frame yields 4 windows identical in pattern to the first (values +16 if the stream continues counting).
- sof_i asserted on pixel 6 of a frame: counters restart at that pixel; first valid window follows the 11th pixel after it (inclusive). rst_ni pulsed mid-frame: window_valid_o=0 and window_o=0 immediately.
- With CONV_WINDOW_GEN_FRAME_DONE_EN: frame_done_o pulses together with the 4th valid window; win_cnt_o reads 4 after the frame and clears on the next sof_i.

Source files
------------

// File: rtl/img_proc_pkg.sv
// ----------------------------------------------------------------------------
// img_proc_pkg
// Shared types and defaults for the image-processing pipeline. The window
// type and its orientation ([row][col], row 0 = oldest line, col 0 = leftmost)
// are defined once here so that the window producer and the convolution stage
// agree exactly.
// ----------------------------------------------------------------------------
package img_proc_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_KERNEL_W = 3;

    typedef logic [DEF_DATA_W-1:0]                     pixel_t;
    typedef pixel_t [DEF_KERNEL_W-1:0][DEF_KERNEL_W-1:0] window_t;

    // Width of a pointer/counter that indexes 0..depth-1 (at least one bit).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// ----------------------------------------------------------------------------
// conv_line_buffer
// Circular delay line of exactly DEPTH accepted samples. On a write-enabled
// cycle the oldest entry is presented on dout (combinational read of the slot
// about to be overwritten) while din replaces it, so dout is the sample that
// was written DEPTH accepted cycles earlier. Storage is not reset.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (pointer only)
//   wr_en         : advance the delay line this cycle
//   din           : sample entering the line
//   dout          : sample leaving the line (DEPTH writes old)
// ----------------------------------------------------------------------------
module conv_line_buffer
    import img_proc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 640
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int PTR_W = ptr_w(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  ptr_r;

    // Sample storage: written in place of the entry being read out.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_r[ptr_r] <= din;
        end
    end

    // Circular pointer, wraps after DEPTH writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_r <= '0;
        end else if (wr_en) begin
            ptr_r <= (ptr_r == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : ptr_r + PTR_W'(1);
        end
    end

    assign dout = mem_r[ptr_r];

endmodule

// File: rtl/conv_window_gen.sv
// ----------------------------------------------------------------------------
// conv_window_gen
// Builds KERNEL_W x KERNEL_W windows from a raster pixel stream using
// KERNEL_W-1 chained line buffers. Only fully populated windows are flagged,
// one clock after the pixel that completes them.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   pixel_i        : raster pixel
//   pixel_valid_i  : pixel_i accepted this cycle
//   sof_i          : the accepted pixel is position (0,0)
//   window_o       : [row][col] window, row 0 = oldest line, col 0 = leftmost
//   window_valid_o : window_o holds a complete window this cycle
// Optional (macro CONV_WINDOW_GEN_FRAME_DONE_EN):
//   frame_done_o   : pulses with the window completed by the last frame pixel
//   win_cnt_o      : valid windows emitted in the current frame
// ----------------------------------------------------------------------------
module conv_window_gen
    import img_proc_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int KERNEL_W = DEF_KERNEL_W,
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [DATA_W-1:0]                             pixel_i,
    input  logic                                          pixel_valid_i,
    input  logic                                          sof_i,
    output logic [KERNEL_W-1:0][KERNEL_W-1:0][DATA_W-1:0] window_o,
    output logic                                          window_valid_o
`ifdef CONV_WINDOW_GEN_FRAME_DONE_EN
    ,
    output logic                                          frame_done_o,
    output logic [31:0]                                   win_cnt_o
`endif
);

    localparam int COL_W = ptr_w(IMG_W);
    localparam int ROW_W = ptr_w(IMG_H);

    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic [COL_W-1:0] cur_col_s;
    logic [ROW_W-1:0] cur_row_s;
    logic [COL_W-1:0] nxt_col_s;
    logic [ROW_W-1:0] nxt_row_s;
    logic             win_ok_s;
    logic             last_px_s;

    logic [DATA_W-1:0] lb_out_s [KERNEL_W-1];
    logic [KERNEL_W-1:0][DATA_W-1:0]                 new_col_s;
    logic [KERNEL_W-1:0][KERNEL_W-1:0][DATA_W-1:0]   window_nxt_s;
    logic [KERNEL_W-1:0][KERNEL_W-1:0][DATA_W-1:0]   window_r;
    logic                                            valid_r;

    // Line buffer chain: buffer k delays by (k+1) lines.
    for (genvar k = 0; k < KERNEL_W - 1; k++) begin : g_lb
        logic [DATA_W-1:0] lb_in_s;
        if (k == 0) begin : g_first
            assign lb_in_s = pixel_i;
        end else begin : g_next
            assign lb_in_s = lb_out_s[k-1];
        end
        conv_line_buffer #(
            .DATA_W (DATA_W),
            .DEPTH  (IMG_W)
        ) u_lb (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .wr_en  (pixel_valid_i),
            .din    (lb_in_s),
            .dout   (lb_out_s[k])
        );
    end

    // Position of the pixel on the input this cycle and the position after it.
    // sof_i forces (0,0) regardless of where the counters stand.
    always_comb begin
        cur_col_s = sof_i ? COL_W'(0) : col_r;
        cur_row_s = sof_i ? ROW_W'(0) : row_r;
        nxt_col_s = cur_col_s + COL_W'(1);
        nxt_row_s = cur_row_s;
        if (cur_col_s == COL_W'(IMG_W - 1)) begin
            nxt_col_s = COL_W'(0);
            nxt_row_s = (cur_row_s == ROW_W'(IMG_H - 1)) ? ROW_W'(0) : cur_row_s + ROW_W'(1);
        end else begin
            nxt_row_s = cur_row_s;
        end
        win_ok_s  = (cur_row_s >= ROW_W'(KERNEL_W - 1)) && (cur_col_s >= COL_W'(KERNEL_W - 1));
        last_px_s = (cur_row_s == ROW_W'(IMG_H - 1)) && (cur_col_s == COL_W'(IMG_W - 1));
    end

    // Next window: shift left, new rightmost column oldest line on row 0.
    always_comb begin
        new_col_s    = '0;
        window_nxt_s = '0;
        new_col_s[KERNEL_W-1] = pixel_i;
        for (int i = 0; i < KERNEL_W - 1; i++) begin
            new_col_s[i] = lb_out_s[KERNEL_W-2-i];
        end
        for (int i = 0; i < KERNEL_W; i++) begin
            for (int j = 0; j < KERNEL_W - 1; j++) begin
                window_nxt_s[i][j] = window_r[i][j+1];
            end
            window_nxt_s[i][KERNEL_W-1] = new_col_s[i];
        end
    end

    // Raster counters, window register and valid strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_r    <= '0;
            row_r    <= '0;
            window_r <= '0;
            valid_r  <= 1'b0;
        end else if (pixel_valid_i) begin
            col_r    <= nxt_col_s;
            row_r    <= nxt_row_s;
            window_r <= window_nxt_s;
            valid_r  <= win_ok_s;
        end else begin
            valid_r  <= 1'b0;
        end
    end

    assign window_o       = window_r;
    assign window_valid_o = valid_r;

`ifdef CONV_WINDOW_GEN_FRAME_DONE_EN
    logic        frame_done_r;
    logic [31:0] win_cnt_r;

    // Frame-done pulse and per-frame window count; the count clears on the
    // first pixel of a frame, which can never complete a window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_done_r <= 1'b0;
            win_cnt_r    <= 32'd0;
        end else if (pixel_valid_i) begin
            frame_done_r <= win_ok_s && last_px_s;
            if ((cur_row_s == ROW_W'(0)) && (cur_col_s == COL_W'(0))) begin
                win_cnt_r <= 32'd0;
            end else if (win_ok_s) begin
                win_cnt_r <= win_cnt_r + 32'd1;
            end
        end else begin
            frame_done_r <= 1'b0;
        end
    end

    assign frame_done_o = frame_done_r;
    assign win_cnt_o    = win_cnt_r;
`endif

endmodule
